// File: rtl/sign_monitor.sv
// -----------------------------------------------------------------------------
// sign_monitor
//   Registered, multi-lane sign classifier for the CORDIC vectoring datapath.
//   For every accepted sample, each lane reports the sign code of its residual,
//   a saturating count of sign flips, and a flag that rises once the residual
//   has stayed within TOLERANCE for CONV_COUNT consecutive samples.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   clear      : synchronous clear of per-lane history
//   in_valid   : input sample valid
//   in_ready   : block can accept a sample (combinational)
//   ans        : packed lanes, lane i at [i*WORD_WIDTH +: WORD_WIDTH]
//   out_valid  : output register holds a result
//   out_ready  : consumer accepts the result
//   sign_ans   : per-lane sign code at [2i +: 2] (00 pos, 10 zero, 01 neg)
//   flip_count : per-lane saturating flip count at [i*CNT_WIDTH +: CNT_WIDTH]
//   converged  : per-lane convergence flag
// -----------------------------------------------------------------------------
module sign_monitor #(
    parameter int WORD_WIDTH = 16,
    parameter int NUM_LANES  = 2,
    parameter int TOLERANCE  = 4,
    parameter int CONV_COUNT = 3,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clear,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_LANES*WORD_WIDTH-1:0] ans,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [2*NUM_LANES-1:0]          sign_ans,
    output logic [NUM_LANES*CNT_WIDTH-1:0]  flip_count,
    output logic [NUM_LANES-1:0]            converged
);

    localparam int RUN_W = $clog2(CONV_COUNT + 1);
    localparam logic [RUN_W-1:0]      RUN_MAX   = RUN_W'(CONV_COUNT);
    localparam logic [RUN_W-1:0]      RUN_ONE   = RUN_W'(1);
    localparam logic [WORD_WIDTH-1:0] TOL       = WORD_WIDTH'(TOLERANCE);
    localparam logic [WORD_WIDTH-1:0] WORD_ONE  = WORD_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  FLIP_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0]  FLIP_ONE  = CNT_WIDTH'(1);
    localparam logic [1:0]            SIGN_POS  = 2'b00;
    localparam logic [1:0]            SIGN_ZERO = 2'b10;
    localparam logic [1:0]            SIGN_NEG  = 2'b01;

    // Sign code of one two's-complement lane value.
    function automatic logic [1:0] classify(input logic [WORD_WIDTH-1:0] x);
        logic [1:0] code;
        if (x[WORD_WIDTH-1]) begin
            code = SIGN_NEG;
        end else if (x == {WORD_WIDTH{1'b0}}) begin
            code = SIGN_ZERO;
        end else begin
            code = SIGN_POS;
        end
        return code;
    endfunction

    logic out_valid_r;
    logic accept_s;

    assign in_ready  = !out_valid_r || out_ready;
    assign accept_s  = in_valid && in_ready;
    assign out_valid = out_valid_r;

    // Output-valid flag: set on accept, dropped when consumed without refill.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [WORD_WIDTH-1:0] x_s;
        logic [WORD_WIDTH-1:0] mag_s;
        logic                  is_neg_s;
        logic                  is_zero_s;
        logic                  in_tol_s;

        // last_vld_r=0 encodes the "none" last sign.
        logic                  last_vld_r;
        logic                  last_neg_r;
        logic [RUN_W-1:0]      run_r;
        logic [CNT_WIDTH-1:0]  flip_r;
        logic [1:0]            sign_r;
        logic                  conv_r;

        logic                  base_vld_s;
        logic                  base_neg_s;
        logic [RUN_W-1:0]      base_run_s;
        logic [CNT_WIDTH-1:0]  base_flip_s;

        logic                  nxt_vld_s;
        logic                  nxt_neg_s;
        logic [RUN_W-1:0]      nxt_run_s;
        logic [CNT_WIDTH-1:0]  nxt_flip_s;
        logic [1:0]            nxt_sign_s;
        logic                  nxt_conv_s;

        assign x_s       = ans[i*WORD_WIDTH +: WORD_WIDTH];
        assign is_neg_s  = x_s[WORD_WIDTH-1];
        assign is_zero_s = (x_s == {WORD_WIDTH{1'b0}});
        // Unsigned view: the most negative input maps to 2^(WORD_WIDTH-1).
        assign mag_s     = is_neg_s ? (~x_s + WORD_ONE) : x_s;
        assign in_tol_s  = (mag_s <= TOL);

        // Next lane state: clear empties history first, then an accepted
        // sample is applied on top of whatever history remains.
        always_comb begin
            base_vld_s  = clear ? 1'b0 : last_vld_r;
            base_neg_s  = clear ? 1'b0 : last_neg_r;
            base_run_s  = clear ? {RUN_W{1'b0}} : run_r;
            base_flip_s = clear ? {CNT_WIDTH{1'b0}} : flip_r;

            nxt_vld_s  = base_vld_s;
            nxt_neg_s  = base_neg_s;
            nxt_run_s  = base_run_s;
            nxt_flip_s = base_flip_s;
            nxt_sign_s = sign_r;
            nxt_conv_s = clear ? 1'b0 : conv_r;

            if (accept_s) begin
                nxt_sign_s = classify(x_s);

                if (is_zero_s) begin
                    nxt_vld_s = base_vld_s;
                end else if (!base_vld_s) begin
                    nxt_vld_s = 1'b1;
                    nxt_neg_s = is_neg_s;
                end else if (base_neg_s != is_neg_s) begin
                    nxt_neg_s  = is_neg_s;
                    nxt_flip_s = (base_flip_s == FLIP_MAX) ? FLIP_MAX
                                                           : base_flip_s + FLIP_ONE;
                end else begin
                    nxt_neg_s = base_neg_s;
                end

                if (!in_tol_s) begin
                    nxt_run_s = {RUN_W{1'b0}};
                end else if (base_run_s >= RUN_MAX) begin
                    nxt_run_s = RUN_MAX;
                end else begin
                    nxt_run_s = base_run_s + RUN_ONE;
                end

                nxt_conv_s = (nxt_run_s == RUN_MAX);
            end else begin
                nxt_sign_s = sign_r;
            end
        end

        // Lane state and registered lane outputs.
        always_ff @(posedge clk) begin
            if (rst) begin
                last_vld_r <= 1'b0;
                last_neg_r <= 1'b0;
                run_r      <= {RUN_W{1'b0}};
                flip_r     <= {CNT_WIDTH{1'b0}};
                sign_r     <= 2'b00;
                conv_r     <= 1'b0;
            end else begin
                last_vld_r <= nxt_vld_s;
                last_neg_r <= nxt_neg_s;
                run_r      <= nxt_run_s;
                flip_r     <= nxt_flip_s;
                sign_r     <= nxt_sign_s;
                conv_r     <= nxt_conv_s;
            end
        end

        assign sign_ans[2*i +: 2]                 = sign_r;
        assign flip_count[i*CNT_WIDTH +: CNT_WIDTH] = flip_r;
        assign converged[i]                       = conv_r;
    end

endmodule

// File: tb/tb_sign_monitor.sv
// -----------------------------------------------------------------------------
// tb_sign_monitor
//   Self-checking bench for sign_monitor (2 lanes x 16 bits). A table of
//   hand-derived vectors plus a behavioural reference model feed a scoreboard
//   queue; each accepted sample's expectation is popped and compared on the
//   cycle its result appears.
// -----------------------------------------------------------------------------
module tb_sign_monitor;

    logic        clk;
    logic        rst;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] ans;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  sign_ans;
    logic [7:0]  flip_count;
    logic [1:0]  converged;

    sign_monitor #(
        .WORD_WIDTH(16), .NUM_LANES(2), .TOLERANCE(4), .CONV_COUNT(3), .CNT_WIDTH(4)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .ans(ans), .out_valid(out_valid), .out_ready(out_ready), .sign_ans(sign_ans),
        .flip_count(flip_count), .converged(converged)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] sign;
        logic [7:0] flip;
        logic [1:0] conv;
    } exp_t;

    typedef struct {
        logic [15:0] l0;
        logic [15:0] l1;
        logic        clr;
        logic [1:0]  s0;
        logic [1:0]  s1;
        logic [3:0]  f0;
        logic [3:0]  f1;
        logic        c0;
        logic        c1;
    } vec_t;

    int   n_chk;
    int   n_fail;
    exp_t sbq[$];
    logic pend;
    exp_t last_out;
    int   m_last[2];
    int   m_run[2];
    int   m_flip[2];
    vec_t tab[13];

    task automatic chk(input bit ok, input string name, input logic [63:0] act,
                       input logic [63:0] req);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_last[i] = 0;
            m_run[i]  = 0;
            m_flip[i] = 0;
        end
    endtask

    task automatic model_apply(input logic [31:0] a, output exp_t e);
        logic signed [15:0] x;
        int v;
        int mag;
        int s;
        e = '0;
        for (int i = 0; i < 2; i++) begin
            x   = a[i*16 +: 16];
            v   = int'(x);
            mag = (v < 0) ? -v : v;
            if (v < 0)       e.sign[2*i +: 2] = 2'b01;
            else if (v == 0) e.sign[2*i +: 2] = 2'b10;
            else             e.sign[2*i +: 2] = 2'b00;
            if (mag <= 4) m_run[i] = (m_run[i] >= 3) ? 3 : m_run[i] + 1;
            else          m_run[i] = 0;
            e.conv[i] = (m_run[i] == 3);
            if (v != 0) begin
                s = (v < 0) ? -1 : 1;
                if (m_last[i] == 0) begin
                    m_last[i] = s;
                end else if (m_last[i] != s) begin
                    if (m_flip[i] < 15) m_flip[i]++;
                    m_last[i] = s;
                end
            end
            e.flip[4*i +: 4] = 4'(m_flip[i]);
        end
    endtask

    // One clock of stimulus: compare the previous accept's result, drive new
    // inputs, and push an expectation if this cycle's sample will be accepted.
    task automatic step(input logic iv, input logic [31:0] a, input logic clr,
                        input logic ordy, input logic use_tab, input exp_t tabexp);
        exp_t e;
        logic acc;
        logic rdy_e;
        @(negedge clk);
        if (pend) begin
            if (sbq.size() == 0) begin
                chk(1'b0, "scoreboard_empty", 64'd0, 64'd1);
            end else begin
                e = sbq.pop_front();
                chk({sign_ans, flip_count, converged} == e, "result",
                    64'({sign_ans, flip_count, converged}), 64'(e));
                chk(out_valid == 1'b1, "out_valid_after_accept", 64'(out_valid), 64'd1);
                last_out = e;
            end
            pend = 1'b0;
        end
        rdy_e     = !out_valid || ordy;
        acc       = iv && rdy_e;
        in_valid  = iv;
        ans       = a;
        clear     = clr;
        out_ready = ordy;
        if (clr) model_clear();
        if (acc) begin
            model_apply(a, e);
            if (use_tab) e = tabexp;
            sbq.push_back(e);
        end
        pend = acc;
        #1;
        chk(in_ready == rdy_e, "in_ready", 64'(in_ready), 64'(rdy_e));
    endtask

    task automatic check_idle_state(input string tag);
        chk(out_valid == 1'b0, {tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk(sign_ans == 4'h0, {tag, "_sign_ans"}, 64'(sign_ans), 64'd0);
        chk(flip_count == 8'h00, {tag, "_flip_count"}, 64'(flip_count), 64'd0);
        chk(converged == 2'b00, {tag, "_converged"}, 64'(converged), 64'd0);
        chk(in_ready == 1'b1, {tag, "_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    logic [15:0] pool[9];
    exp_t        te;
    exp_t        zero_e;

    initial begin
        clk = 1'b0; rst = 1'b1; clear = 1'b0; in_valid = 1'b0; ans = 32'h0;
        out_ready = 1'b1; pend = 1'b0; n_chk = 0; n_fail = 0; last_out = '0;
        zero_e = '0;
        model_clear();

        //          l0        l1        clr   s0     s1     f0    f1    c0    c1
        tab[0]  = '{16'h0F50, 16'hFF50, 1'b0, 2'b00, 2'b01, 4'd0, 4'd0, 1'b0, 1'b0};
        tab[1]  = '{16'h0005, 16'hFF50, 1'b0, 2'b00, 2'b01, 4'd0, 4'd0, 1'b0, 1'b0};
        tab[2]  = '{16'hFFFD, 16'hFF50, 1'b0, 2'b01, 2'b01, 4'd1, 4'd0, 1'b0, 1'b0};
        tab[3]  = '{16'h0000, 16'hFF50, 1'b0, 2'b10, 2'b01, 4'd1, 4'd0, 1'b0, 1'b0};
        tab[4]  = '{16'h0002, 16'hFF50, 1'b0, 2'b00, 2'b01, 4'd2, 4'd0, 1'b1, 1'b0};
        tab[5]  = '{16'h0F50, 16'h0003, 1'b0, 2'b00, 2'b00, 4'd2, 4'd1, 1'b0, 1'b0};
        tab[6]  = '{16'h0F50, 16'hFFFC, 1'b0, 2'b00, 2'b01, 4'd2, 4'd2, 1'b0, 1'b0};
        tab[7]  = '{16'h0F50, 16'h0004, 1'b0, 2'b00, 2'b00, 4'd2, 4'd3, 1'b0, 1'b1};
        tab[8]  = '{16'h0F50, 16'h0005, 1'b0, 2'b00, 2'b00, 4'd2, 4'd3, 1'b0, 1'b0};
        tab[9]  = '{16'hFFFD, 16'h0005, 1'b0, 2'b01, 2'b00, 4'd3, 4'd3, 1'b0, 1'b0};
        tab[10] = '{16'hFFFE, 16'h0005, 1'b1, 2'b01, 2'b00, 4'd0, 4'd0, 1'b0, 1'b0};
        tab[11] = '{16'h0001, 16'h0005, 1'b0, 2'b00, 2'b00, 4'd1, 4'd0, 1'b0, 1'b0};
        tab[12] = '{16'h0000, 16'hFFFB, 1'b0, 2'b10, 2'b01, 4'd1, 4'd1, 1'b1, 1'b0};

        pool = '{16'h0000, 16'h0001, 16'h0004, 16'h0005, 16'hFFFC,
                 16'hFFFB, 16'h8000, 16'h7FFF, 16'hFFFF};

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        check_idle_state("reset");
        rst = 1'b0;

        // Table-driven vectors.
        for (int r = 0; r < 13; r++) begin
            te.sign = {tab[r].s1, tab[r].s0};
            te.flip = {tab[r].f1, tab[r].f0};
            te.conv = {tab[r].c1, tab[r].c0};
            step(1'b1, {tab[r].l1, tab[r].l0}, tab[r].clr, 1'b1, 1'b1, te);
        end

        // Clear without accept: history empties, sign_ans holds.
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, zero_e);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, zero_e);
        chk(flip_count == 8'h00, "clear_flip_count", 64'(flip_count), 64'd0);
        chk(converged == 2'b00, "clear_converged", 64'(converged), 64'd0);
        chk(sign_ans == last_out.sign, "clear_sign_hold", 64'(sign_ans), 64'(last_out.sign));
        chk(out_valid == 1'b0, "clear_out_valid", 64'(out_valid), 64'd0);

        // Most negative input, then alternate extremes until flips saturate.
        step(1'b1, {16'h0000, 16'h8000}, 1'b0, 1'b1, 1'b0, zero_e);
        for (int k = 0; k < 20; k++) begin
            step(1'b1, {16'h0000, (k % 2 == 0) ? 16'h7FFF : 16'h8000}, 1'b0, 1'b1,
                 1'b0, zero_e);
        end
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, zero_e);
        chk(flip_count[3:0] == 4'hF, "flip_saturation", 64'(flip_count[3:0]), 64'hF);

        // Backpressure: accept X with out_ready low, then stall for 3 cycles.
        step(1'b1, {16'h0001, 16'hFFFF}, 1'b0, 1'b0, 1'b0, zero_e);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, {16'h0004, 16'h0002}, 1'b0, 1'b0, 1'b0, zero_e);
            chk({sign_ans, flip_count, converged} == last_out, "stall_frozen",
                64'({sign_ans, flip_count, converged}), 64'(last_out));
            chk(out_valid == 1'b1, "stall_out_valid", 64'(out_valid), 64'd1);
        end
        step(1'b1, {16'h0004, 16'h0002}, 1'b0, 1'b1, 1'b0, zero_e);
        step(1'b1, {16'hFFFC, 16'h0003}, 1'b0, 1'b1, 1'b0, zero_e);
        step(1'b1, {16'h0000, 16'hFFFE}, 1'b0, 1'b1, 1'b0, zero_e);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, zero_e);

        // Reset mid-stream with a pending, unconsumed output.
        step(1'b1, {16'hFFFF, 16'h0003}, 1'b0, 1'b0, 1'b0, zero_e);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        pend = 1'b0;
        sbq.delete();
        @(negedge clk);
        #1;
        check_idle_state("midreset");
        rst = 1'b0;
        model_clear();

        // Randomised tail with random backpressure and occasional clear.
        for (int k = 0; k < 60; k++) begin
            step(1'($urandom_range(3, 0) != 0),
                 {pool[$urandom_range(8, 0)], pool[$urandom_range(8, 0)]},
                 1'($urandom_range(15, 0) == 0), 1'($urandom_range(3, 0) != 0),
                 1'b0, zero_e);
        end
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, zero_e);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, zero_e);
        chk(sbq.size() == 0, "scoreboard_drained", 64'(sbq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
